// File: rtl/sdram_emulator.sv
// SDR SDRAM device responder. Decodes the controller's command bus, tracks
// per-bank open state and tRCD, serves reads/writes from an on-chip RAM and
// raises a sticky err flag on protocol violations. Burst length is fixed at 1.
module sdram_emulator #(
    parameter int CAS_LATENCY   = 2,
    parameter int TRCD          = 2,
    parameter int ROW_BITS      = 13,
    parameter int COL_BITS      = 9,
    parameter int MEM_ADDR_BITS = 12
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        sdram_cke,
    input  logic        sdram_cs_n,
    input  logic        sdram_ras_n,
    input  logic        sdram_cas_n,
    input  logic        sdram_we_n,
    input  logic [12:0] sdram_a,
    input  logic [1:0]  sdram_ba,
    input  logic [1:0]  sdram_dm,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        err,
    output logic [15:0] refresh_cnt
);

    localparam int TW        = (TRCD > 1) ? $clog2(TRCD) : 1;
    localparam int FULL_BITS = 2 + ROW_BITS + COL_BITS;
    localparam int DEPTH     = 1 << MEM_ADDR_BITS;

    typedef enum logic [2:0] {
        CMD_LMR = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_t;

    cmd_t                     cmd;
    logic                     cmd_en;
    logic [3:0]               bank_open;
    logic [ROW_BITS-1:0]      bank_row [4];
    logic [TW-1:0]            trcd_cnt [4];
    logic                     cl3;
    logic [15:0]              mem [DEPTH];

    // Read pipeline: s0 only used for CL=3, s1 feeds the output register.
    logic                     s0_valid;
    logic                     s1_valid;
    logic [MEM_ADDR_BITS-1:0] s0_idx;
    logic [MEM_ADDR_BITS-1:0] s1_idx;

    logic                     sel_open;
    logic                     sel_ready;
    logic [FULL_BITS-1:0]     full_addr;
    logic [MEM_ADDR_BITS-1:0] idx;
    logic                     do_act;
    logic                     do_pre;
    logic                     do_ref;
    logic                     rd_go;
    logic                     wr_go;
    logic                     cl_set;
    logic                     new_cl3;
    logic                     err_set;

    assign cmd    = cmd_t'({sdram_ras_n, sdram_cas_n, sdram_we_n});
    assign cmd_en = sdram_cke & ~sdram_cs_n;

    // Command decode and protocol checks against the current bank state.
    always_comb begin
        do_act    = 1'b0;
        do_pre    = 1'b0;
        do_ref    = 1'b0;
        rd_go     = 1'b0;
        wr_go     = 1'b0;
        cl_set    = 1'b0;
        new_cl3   = cl3;
        err_set   = 1'b0;
        sel_open  = bank_open[sdram_ba];
        sel_ready = (trcd_cnt[sdram_ba] == '0);
        full_addr = {sdram_ba, bank_row[sdram_ba], sdram_a[COL_BITS-1:0]};
        // Upper address bits alias onto the smaller backing store.
        idx       = MEM_ADDR_BITS'(full_addr);
        if (cmd_en) begin
            case (cmd)
                CMD_ACT: begin
                    do_act = 1'b1;
                    if (sel_open) err_set = 1'b1;
                end
                CMD_RD: begin
                    if (!sel_open) begin
                        err_set = 1'b1;
                    end else begin
                        rd_go = 1'b1;
                        if (!sel_ready) err_set = 1'b1;
                    end
                end
                CMD_WR: begin
                    if (!sel_open) begin
                        err_set = 1'b1;
                    end else begin
                        wr_go = 1'b1;
                        if (!sel_ready) err_set = 1'b1;
                    end
                    // Bus turnaround: a write while a read beat is pending or on the bus.
                    if (s0_valid || s1_valid || dq_oe) err_set = 1'b1;
                end
                CMD_PRE: do_pre = 1'b1;
                CMD_REF: begin
                    if (|bank_open) err_set = 1'b1;
                    else            do_ref  = 1'b1;
                end
                CMD_LMR: begin
                    if (|bank_open) begin
                        err_set = 1'b1;
                    end else if (sdram_a[6:4] == 3'd2 || sdram_a[6:4] == 3'd3) begin
                        cl_set  = 1'b1;
                        new_cl3 = (sdram_a[6:4] == 3'd3);
                    end else begin
                        err_set = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-bank open flag, open row and tRCD countdown.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                bank_open[b] <= 1'b0;
                bank_row[b]  <= '0;
                trcd_cnt[b]  <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (do_act && sdram_ba == 2'(b)) begin
                    bank_open[b] <= 1'b1;
                    bank_row[b]  <= sdram_a[ROW_BITS-1:0];
                    trcd_cnt[b]  <= TW'(TRCD - 1);
                end else begin
                    if (do_pre && (sdram_a[10] || sdram_ba == 2'(b))) bank_open[b] <= 1'b0;
                    if (trcd_cnt[b] != '0) trcd_cnt[b] <= trcd_cnt[b] - TW'(1);
                end
            end
        end
    end

    // Mode register, sticky error flag and saturating refresh counter.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            cl3         <= (CAS_LATENCY == 3);
            err         <= 1'b0;
            refresh_cnt <= '0;
        end else begin
            if (cl_set) cl3 <= new_cl3;
            if (err_set) err <= 1'b1;
            if (do_ref && refresh_cnt != 16'hFFFF) refresh_cnt <= refresh_cnt + 16'd1;
        end
    end

    // Read pipeline: the beat enters at a depth chosen by the CL active now.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_idx   <= '0;
            s1_valid <= 1'b0;
            s1_idx   <= '0;
        end else begin
            s0_valid <= rd_go & cl3;
            s0_idx   <= idx;
            if (rd_go && !cl3) begin
                s1_valid <= 1'b1;
                s1_idx   <= idx;
            end else begin
                s1_valid <= s0_valid;
                s1_idx   <= s0_idx;
            end
        end
    end

    // Backing store write with byte masks; a set dm bit keeps the old byte.
    always_ff @(posedge clk_sys) begin
        if (wr_go) begin
            if (!sdram_dm[0]) mem[idx][7:0]  <= dq_in[7:0];
            if (!sdram_dm[1]) mem[idx][15:8] <= dq_in[15:8];
        end
    end

    // Output register; reads the RAM on the same edge as a write, so old data wins.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            dq_oe  <= 1'b0;
            dq_out <= '0;
        end else begin
            dq_oe  <= s1_valid;
            dq_out <= s1_valid ? mem[s1_idx] : 16'h0000;
        end
    end

endmodule

// File: tb/tb_sdram_emulator.sv
// Directed bench for sdram_emulator with hand-computed expectations.
module tb_sdram_emulator;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        sdram_cke = 1'b1;
    logic        sdram_cs_n = 1'b1;
    logic        sdram_ras_n = 1'b1;
    logic        sdram_cas_n = 1'b1;
    logic        sdram_we_n = 1'b1;
    logic [12:0] sdram_a = '0;
    logic [1:0]  sdram_ba = '0;
    logic [1:0]  sdram_dm = '0;
    logic [15:0] dq_in = '0;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        err;
    logic [15:0] refresh_cnt;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_LMR = 3'b000;

    sdram_emulator dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .sdram_cke   (sdram_cke),
        .sdram_cs_n  (sdram_cs_n),
        .sdram_ras_n (sdram_ras_n),
        .sdram_cas_n (sdram_cas_n),
        .sdram_we_n  (sdram_we_n),
        .sdram_a     (sdram_a),
        .sdram_ba    (sdram_ba),
        .sdram_dm    (sdram_dm),
        .dq_in       (dq_in),
        .dq_out      (dq_out),
        .dq_oe       (dq_oe),
        .err         (err),
        .refresh_cnt (refresh_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one command for one rising edge, then return 1 time unit after it.
    task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic [15:0] d, input logic [1:0] m);
        sdram_cs_n = 1'b0;
        {sdram_ras_n, sdram_cas_n, sdram_we_n} = c;
        sdram_ba = ba;
        sdram_a  = a;
        dq_in    = d;
        sdram_dm = m;
        @(posedge clk_sys);
        #1;
        sdram_cs_n = 1'b1;
        {sdram_ras_n, sdram_cas_n, sdram_we_n} = C_NOP;
    endtask

    task automatic nop();
        issue(C_NOP, 2'd0, 13'h0, 16'h0, 2'b00);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_dq_out", {16'h0, dq_out}, 32'h0);
        chk("rst_dq_oe", {31'h0, dq_oe}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_refresh", {16'h0, refresh_cnt}, 32'h0);
        @(negedge clk_sys);
        rst = 1'b0;

        // Basic write then read at CL=2
        issue(C_ACT, 2'd1, 13'h0055, 16'h0, 2'b00);
        nop();
        nop();
        issue(C_WR, 2'd1, 13'h0003, 16'hBEEF, 2'b00);
        issue(C_PRE, 2'd0, 13'h0400, 16'h0, 2'b00);
        issue(C_ACT, 2'd1, 13'h0055, 16'h0, 2'b00);
        nop();
        issue(C_RD, 2'd1, 13'h0003, 16'h0, 2'b00);
        chk("cl2_t0_oe", {31'h0, dq_oe}, 32'h0);
        nop();
        chk("cl2_t1_oe", {31'h0, dq_oe}, 32'h1);
        chk("cl2_t1_data", {16'h0, dq_out}, 32'h0000BEEF);
        nop();
        chk("cl2_t2_oe", {31'h0, dq_oe}, 32'h0);
        chk("cl2_err", {31'h0, err}, 32'h0);

        // Byte-masked write merges with the earlier word
        issue(C_WR, 2'd1, 13'h0005, 16'h1234, 2'b00);
        issue(C_WR, 2'd1, 13'h0005, 16'hABCD, 2'b01);
        nop();
        issue(C_RD, 2'd1, 13'h0005, 16'h0, 2'b00);
        nop();
        chk("mask_oe", {31'h0, dq_oe}, 32'h1);
        chk("mask_data", {16'h0, dq_out}, 32'h0000AB34);
        nop();
        chk("mask_err", {31'h0, err}, 32'h0);

        // Refresh with banks closed, then with bank 0 open
        issue(C_PRE, 2'd0, 13'h0400, 16'h0, 2'b00);
        for (int i = 0; i < 5; i++) issue(C_REF, 2'd0, 13'h0, 16'h0, 2'b00);
        chk("ref5_cnt", {16'h0, refresh_cnt}, 32'd5);
        chk("ref5_err", {31'h0, err}, 32'h0);
        issue(C_ACT, 2'd0, 13'h0000, 16'h0, 2'b00);
        issue(C_REF, 2'd0, 13'h0, 16'h0, 2'b00);
        chk("ref_open_cnt", {16'h0, refresh_cnt}, 32'd5);
        chk("ref_open_err", {31'h0, err}, 32'h1);

        // Reset clears flags but not the RAM; then CL=3 read
        pulse_reset();
        chk("rst2_err", {31'h0, err}, 32'h0);
        chk("rst2_refresh", {16'h0, refresh_cnt}, 32'h0);
        issue(C_LMR, 2'd0, 13'h0030, 16'h0, 2'b00);
        issue(C_ACT, 2'd1, 13'h0055, 16'h0, 2'b00);
        nop();
        issue(C_RD, 2'd1, 13'h0003, 16'h0, 2'b00);
        chk("cl3_t0_oe", {31'h0, dq_oe}, 32'h0);
        nop();
        chk("cl3_t1_oe", {31'h0, dq_oe}, 32'h0);
        nop();
        chk("cl3_t2_oe", {31'h0, dq_oe}, 32'h1);
        chk("cl3_t2_data", {16'h0, dq_out}, 32'h0000BEEF);
        nop();
        chk("cl3_t3_oe", {31'h0, dq_oe}, 32'h0);
        chk("cl3_err", {31'h0, err}, 32'h0);

        // Illegal CL value sets err and keeps CL=3
        issue(C_PRE, 2'd0, 13'h0400, 16'h0, 2'b00);
        issue(C_LMR, 2'd0, 13'h0050, 16'h0, 2'b00);
        chk("bad_cl_err", {31'h0, err}, 32'h1);
        issue(C_ACT, 2'd1, 13'h0055, 16'h0, 2'b00);
        nop();
        issue(C_RD, 2'd1, 13'h0003, 16'h0, 2'b00);
        nop();
        chk("bad_cl_t1_oe", {31'h0, dq_oe}, 32'h0);
        nop();
        chk("bad_cl_t2_oe", {31'h0, dq_oe}, 32'h1);
        chk("bad_cl_t2_data", {16'h0, dq_out}, 32'h0000BEEF);
        nop();

        // READ on a closed bank: err, nothing driven
        pulse_reset();
        issue(C_RD, 2'd2, 13'h0003, 16'h0, 2'b00);
        chk("rd_closed_err", {31'h0, err}, 32'h1);
        nop();
        chk("rd_closed_t1_oe", {31'h0, dq_oe}, 32'h0);
        nop();
        chk("rd_closed_t2_oe", {31'h0, dq_oe}, 32'h0);

        // READ inside tRCD: err, but data still returned at CL=2
        pulse_reset();
        issue(C_ACT, 2'd1, 13'h0055, 16'h0, 2'b00);
        issue(C_RD, 2'd1, 13'h0003, 16'h0, 2'b00);
        chk("trcd_err", {31'h0, err}, 32'h1);
        nop();
        chk("trcd_oe", {31'h0, dq_oe}, 32'h1);
        chk("trcd_data", {16'h0, dq_out}, 32'h0000BEEF);
        nop();

        // Reset one clock after a CL=3 read drops the pending beat
        pulse_reset();
        issue(C_LMR, 2'd0, 13'h0030, 16'h0, 2'b00);
        issue(C_ACT, 2'd1, 13'h0055, 16'h0, 2'b00);
        nop();
        issue(C_RD, 2'd1, 13'h0003, 16'h0, 2'b00);
        nop();
        rst = 1'b1;
        #1;
        chk("midrd_rst_out", {16'h0, dq_out}, 32'h0);
        chk("midrd_rst_oe", {31'h0, dq_oe}, 32'h0);
        #1;
        rst = 1'b0;
        nop();
        chk("midrd_t2_oe", {31'h0, dq_oe}, 32'h0);
        nop();
        chk("midrd_t3_oe", {31'h0, dq_oe}, 32'h0);
        chk("midrd_err", {31'h0, err}, 32'h0);
        chk("midrd_out", {16'h0, dq_out}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
